mem_bus_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one PicoRV32-style mem_* master port (feeding the mem->AXI4-Lite

---
 rtl/mem_bus_rr_arbiter_if.sv | 37 +++
 rtl/mem_bus_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_bus_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_rr_arbiter_if.sv
// Shared memory-bus bundle: NUM_REQ requester ports on one side, and a single
// PicoRV32-style mem_* master port toward the downstream adapter on the other.
interface mem_bus_rr_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_instr;
    logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata;
    logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb;
    logic [NUM_REQ-1:0]              req_ready;
    logic [DATA_WIDTH-1:0]           req_rdata;

    logic                    m_mem_valid;
    logic                    m_mem_instr;
    logic [ADDR_WIDTH-1:0]   m_mem_addr;
    logic [DATA_WIDTH-1:0]   m_mem_wdata;
    logic [DATA_WIDTH/8-1:0] m_mem_wstrb;
    logic                    m_mem_ready;
    logic [DATA_WIDTH-1:0]   m_mem_rdata;

    modport slave (
        input  req_valid, req_instr, req_addr, req_wdata, req_wstrb,
        output req_ready, req_rdata,
        output m_mem_valid, m_mem_instr, m_mem_addr, m_mem_wdata, m_mem_wstrb,
        input  m_mem_ready, m_mem_rdata
    );

    modport master (
        output req_valid, req_instr, req_addr, req_wdata, req_wstrb,
        input  req_ready, req_rdata,
        input  m_mem_valid, m_mem_instr, m_mem_addr, m_mem_wdata, m_mem_wstrb,
        output m_mem_ready, m_mem_rdata
    );
endinterface

// File: rtl/mem_bus_rr_arbiter.sv
// Round-robin arbiter sharing one mem_* master port between NUM_REQ requesters, with a
// watchdog that completes a stuck transaction with ERR_DATA and then drains the late reply.
module mem_bus_rr_arbiter #(
    parameter int                    NUM_REQ        = 2,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter int                    CNT_WIDTH      = 16,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(32'hDEAD_BEEF),
    localparam int                   GW             = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_bus_rr_arbiter_if.slave  bus,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 timeout_err,
    input  logic                 timeout_clr
);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] WD_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_instr_q, m_instr_d;
    logic [ADDR_WIDTH-1:0]  m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0]  m_wdata_q, m_wdata_d;
    logic [SW-1:0]          m_wstrb_q, m_wstrb_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   terr_q, terr_d;

    logic                   win_found;
    logic [GW-1:0]          win_idx;
    logic                   done_ok;
    logic                   wd_fire;

    // First valid requester at or after ptr_q, wrapping around.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr_q) + i) % NUM_REQ;
            if (!win_found && bus.req_valid[j]) begin
                win_found = 1'b1;
                win_idx   = GW'(j);
            end
        end
    end

    // A normal completion always beats a watchdog fire in the same cycle.
    assign done_ok = (state_q == BUSY) && bus.m_mem_ready;
    assign wd_fire = (state_q == BUSY) && !bus.m_mem_ready &&
                     (TIMEOUT_CYCLES != 0) && (cnt_q == WD_LAST);

    always_comb begin
        bus.req_ready = '0;
        bus.req_rdata = '0;
        if (done_ok) begin
            bus.req_ready[grant_q] = 1'b1;
            bus.req_rdata          = bus.m_mem_rdata;
        end else if (wd_fire) begin
            bus.req_ready[grant_q] = 1'b1;
            bus.req_rdata          = ERR_DATA;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_instr_d = m_instr_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    m_valid_d = 1'b1;
                    m_instr_d = bus.req_instr[win_idx];
                    m_addr_d  = bus.req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    m_wdata_d = bus.req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    m_wstrb_d = bus.req_wstrb[int'(win_idx)*SW +: SW];
                    grant_d   = win_idx;
                    ptr_d     = (win_idx == GW'(NUM_REQ - 1)) ? '0 : win_idx + GW'(1);
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (done_ok) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end else if (wd_fire) begin
                    m_valid_d = 1'b0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                // The abandoned transaction's reply is absorbed here, never forwarded.
                if (bus.m_mem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign terr_d = wd_fire ? 1'b1 : (timeout_clr ? 1'b0 : terr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            m_instr_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            grant_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_instr_q <= m_instr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
        end
    end

    assign bus.m_mem_valid = m_valid_q;
    assign bus.m_mem_instr = m_instr_q;
    assign bus.m_mem_addr  = m_addr_q;
    assign bus.m_mem_wdata = m_wdata_q;
    assign bus.m_mem_wstrb = m_wstrb_q;
    assign grant_id        = grant_q;
    assign busy            = (state_q != IDLE);
    assign timeout_err     = terr_q;
endmodule

// File: tb/tb_mem_bus_rr_arbiter.sv
// Directed bench for mem_bus_rr_arbiter: a cycle table for single reads and contention,
// then hand-written sequences for write hold, watchdog, drain, priority cases and reset.
module tb_mem_bus_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic grant_id;
    logic busy;
    logic timeout_err;
    logic timeout_clr;

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_rr_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_bus_rr_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8), .CNT_WIDTH(16), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err), .timeout_clr(timeout_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  vld;
        logic        rdy;
        logic [31:0] rdata;
        logic        mv;
        logic [31:0] addr;
        logic [1:0]  rr;
        logic [31:0] erd;
        logic        gid;
        logic        bsy;
    } vec_t;

    vec_t tbl [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_payload();
        bus.req_instr = 2'b10;
        bus.req_addr  = {32'h0000_0200, 32'h0000_0100};
        bus.req_wdata = {32'hA5A5_A5A5, 32'h0000_0000};
        bus.req_wstrb = {4'b0011, 4'b0000};
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        // vld, rdy, rdata, mv, addr, rr, erd, gid, bsy
        tbl[0]  = '{2'b01, 1'b0, 32'h0,         1'b0, 32'h000, 2'b00, 32'h0,         1'b0, 1'b0};
        tbl[1]  = '{2'b01, 1'b0, 32'h0,         1'b1, 32'h100, 2'b00, 32'h0,         1'b0, 1'b1};
        tbl[2]  = '{2'b01, 1'b1, 32'h1234_5678, 1'b1, 32'h100, 2'b01, 32'h1234_5678, 1'b0, 1'b1};
        tbl[3]  = '{2'b00, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h100, 2'b00, 32'h0,         1'b0, 1'b0};
        tbl[4]  = '{2'b11, 1'b0, 32'h0,         1'b0, 32'h100, 2'b00, 32'h0,         1'b0, 1'b0};
        tbl[5]  = '{2'b11, 1'b0, 32'h0,         1'b1, 32'h200, 2'b00, 32'h0,         1'b1, 1'b1};
        tbl[6]  = '{2'b11, 1'b1, 32'h1111_1111, 1'b1, 32'h200, 2'b10, 32'h1111_1111, 1'b1, 1'b1};
        tbl[7]  = '{2'b11, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h200, 2'b00, 32'h0,         1'b1, 1'b0};
        tbl[8]  = '{2'b11, 1'b0, 32'h0,         1'b1, 32'h100, 2'b00, 32'h0,         1'b0, 1'b1};
        tbl[9]  = '{2'b11, 1'b1, 32'h2222_2222, 1'b1, 32'h100, 2'b01, 32'h2222_2222, 1'b0, 1'b1};
        tbl[10] = '{2'b11, 1'b0, 32'h0,         1'b0, 32'h100, 2'b00, 32'h0,         1'b0, 1'b0};
        tbl[11] = '{2'b11, 1'b1, 32'h3333_3333, 1'b1, 32'h200, 2'b10, 32'h3333_3333, 1'b1, 1'b1};
        tbl[12] = '{2'b00, 1'b0, 32'h0,         1'b0, 32'h200, 2'b00, 32'h0,         1'b1, 1'b0};
        tbl[13] = '{2'b00, 1'b0, 32'h0,         1'b0, 32'h200, 2'b00, 32'h0,         1'b1, 1'b0};

        rst_n           = 1'b0;
        timeout_clr     = 1'b0;
        bus.req_valid   = 2'b00;
        bus.m_mem_ready = 1'b0;
        bus.m_mem_rdata = 32'h0;
        set_payload();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mvalid", 32'(bus.m_mem_valid), 32'h0);
        chk("rst_addr",   bus.m_mem_addr,       32'h0);
        chk("rst_wdata",  bus.m_mem_wdata,      32'h0);
        chk("rst_wstrb",  32'(bus.m_mem_wstrb), 32'h0);
        chk("rst_instr",  32'(bus.m_mem_instr), 32'h0);
        chk("rst_ready",  32'(bus.req_ready),   32'h0);
        chk("rst_rdata",  bus.req_rdata,        32'h0);
        chk("rst_grant",  32'(grant_id),        32'h0);
        chk("rst_busy",   32'(busy),            32'h0);
        chk("rst_terr",   32'(timeout_err),     32'h0);
        rst_n = 1'b1;

        for (int r = 0; r < 14; r++) begin
            bus.req_valid   = tbl[r].vld;
            bus.m_mem_ready = tbl[r].rdy;
            bus.m_mem_rdata = tbl[r].rdata;
            #1;
            chk($sformatf("tbl%0d_mvalid", r), 32'(bus.m_mem_valid), 32'(tbl[r].mv));
            chk($sformatf("tbl%0d_addr", r),   bus.m_mem_addr,       tbl[r].addr);
            chk($sformatf("tbl%0d_ready", r),  32'(bus.req_ready),   32'(tbl[r].rr));
            chk($sformatf("tbl%0d_rdata", r),  bus.req_rdata,        tbl[r].erd);
            chk($sformatf("tbl%0d_grant", r),  32'(grant_id),        32'(tbl[r].gid));
            chk($sformatf("tbl%0d_busy", r),   32'(busy),            32'(tbl[r].bsy));
            tick();
        end
        bus.m_mem_ready = 1'b0;
        bus.m_mem_rdata = 32'h0;

        // Write passthrough, payload held while requester 1 changes its inputs.
        bus.req_valid = 2'b10;
        tick();
        #1;
        chk("wr_mvalid", 32'(bus.m_mem_valid), 32'h1);
        chk("wr_addr",   bus.m_mem_addr,       32'h200);
        chk("wr_wdata",  bus.m_mem_wdata,      32'hA5A5_A5A5);
        chk("wr_wstrb",  32'(bus.m_mem_wstrb), 32'h3);
        chk("wr_instr",  32'(bus.m_mem_instr), 32'h1);
        bus.req_addr[63:32]  = 32'h0000_0FFF;
        bus.req_wdata[63:32] = 32'h0;
        bus.req_wstrb[7:4]   = 4'hF;
        bus.req_instr[1]     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wr_hold_wdata", bus.m_mem_wdata,      32'hA5A5_A5A5);
            chk("wr_hold_addr",  bus.m_mem_addr,       32'h200);
            chk("wr_hold_wstrb", 32'(bus.m_mem_wstrb), 32'h3);
        end
        bus.m_mem_ready = 1'b1;
        bus.m_mem_rdata = 32'h0000_55AA;
        #1;
        chk("wr_ready", 32'(bus.req_ready), 32'h2);
        chk("wr_rdata", bus.req_rdata,      32'h0000_55AA);
        tick();
        bus.m_mem_ready = 1'b0;
        bus.req_valid   = 2'b00;
        set_payload();

        // Watchdog fires on the 8th BUSY cycle.
        bus.req_valid = 2'b01;
        tick();
        for (int k = 1; k <= 7; k++) begin
            #1;
            chk($sformatf("wd_quiet%0d", k), 32'(bus.req_ready), 32'h0);
            tick();
        end
        #1;
        chk("wd_ready", 32'(bus.req_ready), 32'h1);
        chk("wd_rdata", bus.req_rdata,      32'hDEAD_BEEF);
        tick();
        #1;
        chk("wd_terr",  32'(timeout_err),     32'h1);
        chk("wd_drain", 32'(busy),            32'h1);
        for (int k = 0; k < 3; k++) begin
            chk("drain_mvalid", 32'(bus.m_mem_valid), 32'h0);
            chk("drain_ready",  32'(bus.req_ready),   32'h0);
            tick();
        end
        bus.m_mem_ready = 1'b1;
        bus.m_mem_rdata = 32'h0000_0077;
        #1;
        chk("late_ready_swallowed", 32'(bus.req_ready), 32'h0);
        chk("late_rdata_zero",      bus.req_rdata,      32'h0);
        tick();
        bus.m_mem_ready = 1'b0;
        #1;
        chk("post_drain_idle", 32'(busy), 32'h0);
        tick();
        #1;
        chk("post_drain_grant",  32'(bus.m_mem_valid), 32'h1);
        chk("post_drain_addr",   bus.m_mem_addr,       32'h100);
        bus.m_mem_ready = 1'b1;
        bus.m_mem_rdata = 32'h0000_4444;
        #1;
        chk("post_drain_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.m_mem_ready = 1'b0;
        bus.req_valid   = 2'b00;

        // Clear the sticky flag, then complete exactly on the watchdog cycle.
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        #1;
        chk("clr_terr", 32'(timeout_err), 32'h0);
        bus.req_valid = 2'b01;
        tick();
        for (int k = 1; k <= 7; k++) tick();
        bus.m_mem_ready = 1'b1;
        bus.m_mem_rdata = 32'h0BAD_F00D;
        #1;
        chk("race_ready", 32'(bus.req_ready), 32'h1);
        chk("race_rdata", bus.req_rdata,      32'h0BAD_F00D);
        tick();
        bus.m_mem_ready = 1'b0;
        bus.req_valid   = 2'b00;
        #1;
        chk("race_terr", 32'(timeout_err), 32'h0);
        chk("race_idle", 32'(busy),        32'h0);

        // Clear and fire in the same cycle: the flag must end up set.
        bus.req_valid = 2'b01;
        tick();
        for (int k = 1; k <= 7; k++) tick();
        timeout_clr = 1'b1;
        #1;
        chk("clrfire_rdata", bus.req_rdata, 32'hDEAD_BEEF);
        tick();
        timeout_clr   = 1'b0;
        bus.req_valid = 2'b00;
        #1;
        chk("clrfire_terr", 32'(timeout_err), 32'h1);
        bus.m_mem_ready = 1'b1;
        tick();
        bus.m_mem_ready = 1'b0;
        #1;
        chk("clrfire_idle", 32'(busy), 32'h0);

        // Asynchronous reset while BUSY.
        bus.req_valid = 2'b10;
        tick();
        #1;
        chk("rstb_busy",  32'(busy),     32'h1);
        chk("rstb_grant", 32'(grant_id), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstm_mvalid", 32'(bus.m_mem_valid), 32'h0);
        chk("rstm_addr",   bus.m_mem_addr,       32'h0);
        chk("rstm_wdata",  bus.m_mem_wdata,      32'h0);
        chk("rstm_grant",  32'(grant_id),        32'h0);
        chk("rstm_busy",   32'(busy),            32'h0);
        chk("rstm_terr",   32'(timeout_err),     32'h0);
        chk("rstm_ready",  32'(bus.req_ready),   32'h0);
        rst_n         = 1'b1;
        bus.req_valid = 2'b11;
        tick();
        #1;
        chk("rsta_grant", 32'(grant_id),       32'h0);
        chk("rsta_addr",  bus.m_mem_addr,      32'h100);
        chk("rsta_mvalid", 32'(bus.m_mem_valid), 32'h1);
        bus.m_mem_ready = 1'b1;
        tick();
        bus.m_mem_ready = 1'b0;
        bus.req_valid   = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
